clock_divider_ctrl: RTL

Run/pause/stop controller and rate scheduler for the free-running divider counter. It sequences an (N+1)-bit divide counter and produces a single-cycle TickOut clock-enable at a selectable rate, plus the four MSB taps (ClkOut). Rate changes arrive through a valid/ready config port and are applied only on tick boundaries, so downstream counters and debouncers never see a short period.

---
 rtl/clock_divider_ctrl_pkg.sv | 14 +
 rtl/clock_divider_ctrl_counter.sv | 21 ++
 rtl/clock_divider_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/clock_divider_ctrl_pkg.sv
// Shared definitions for the clock divider controller: state encoding,
// rate-select width and the smallest legal counter MSB index.
package clock_divider_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2
   } state_t;

   localparam int SELW  = 2;
   localparam int N_MIN = 3;

endpackage

// File: rtl/clock_divider_ctrl_counter.sv
// Free-running (N+1)-bit divide counter with synchronous clear and count enable.
module clkdiv_counter #(
   parameter int N = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       enable,
   output logic [N:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + {{N{1'b0}}, 1'b1};
   end

endmodule

// File: rtl/clock_divider_ctrl.sv
// Run/pause/stop sequencer and rate scheduler around the divide counter;
// rate changes requested while running take effect on a tick boundary.
module clock_divider_ctrl
   import clock_divider_ctrl_pkg::*;
#(
   parameter int N = 5
) (
   input  logic            ClkIn,
   input  logic            Reset_n,
   input  logic            Start,
   input  logic            Stop,
   input  logic            Pause,
   input  logic            CfgValid,
   input  logic [SELW-1:0] CfgSel,
   output logic            CfgReady,
   output logic            TickOut,
   output logic [3:0]      ClkOut,
   output logic            Running,
   output logic [SELW-1:0] SelOut
);

   if (N < N_MIN) begin : g_n_check
      $error("clock_divider_ctrl: N must be >= 3");
   end

   state_t          state, state_nx;
   logic [N:0]      count, count_inc, mask;
   logic            cnt_en, cnt_clr, tick_d, cfg_fire, pending;
   logic [SELW-1:0] sel, pend_sel;

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (!Stop && !Pause && Start) state_nx = ST_RUN;
         ST_RUN:    if (Stop) state_nx = ST_IDLE;
                    else if (Pause) state_nx = ST_PAUSED;
         ST_PAUSED: if (Stop) state_nx = ST_IDLE;
                    else if (!Pause && Start) state_nx = ST_RUN;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge ClkIn or negedge Reset_n) begin
      if (!Reset_n) state <= ST_IDLE;
      else          state <= state_nx;
   end

   // Counting only when staying in RUN keeps phase intact across a pause
   // and guarantees no tick lands on the edge that leaves RUN.
   assign cnt_en  = (state == ST_RUN) && (state_nx == ST_RUN);
   assign cnt_clr = (state_nx == ST_IDLE);

   clkdiv_counter #(.N(N)) u_counter (
      .clk    (ClkIn),
      .rst_n  (Reset_n),
      .clear  (cnt_clr),
      .enable (cnt_en),
      .count  (count)
   );

   // Low field L of the selected width; Sel=3 spans the whole counter.
   always_comb begin
      count_inc = count + {{N{1'b0}}, 1'b1};
      mask      = ({{N{1'b0}}, 1'b1} << (N - 2 + int'(sel))) - {{N{1'b0}}, 1'b1};
      tick_d    = cnt_en && ((count_inc & mask) == '0);
   end

   assign cfg_fire = CfgValid && !pending;

   always_ff @(posedge ClkIn or negedge Reset_n) begin
      if (!Reset_n) begin
         TickOut  <= 1'b0;
         sel      <= '0;
         pend_sel <= '0;
         pending  <= 1'b0;
      end else begin
         TickOut <= tick_d;
         if (cfg_fire && state != ST_RUN)
            sel <= CfgSel;
         if (state_nx == ST_IDLE) begin
            pending <= 1'b0;
         end else if (state == ST_RUN) begin
            if (tick_d && pending) begin
               sel     <= pend_sel;
               pending <= 1'b0;
            end else if (cfg_fire) begin
               pend_sel <= CfgSel;
               pending  <= 1'b1;
            end
         end
      end
   end

   assign CfgReady = !pending;
   assign Running  = (state == ST_RUN);
   assign SelOut   = sel;
   assign ClkOut   = (state == ST_IDLE) ? 4'd0 : count[N:N-3];

endmodule
